debug_data_sender: RTL and testbench
====================================

Name: debug_data_sender

Overview:
Transmit side of the debug unit's send handshake. It answers the step/run FSM's send-start pulse by dumping a processor snapshot over the UART transmitter, one byte at a time. The snapshot is PC, clock count, register file and data memory. It pulses send-done when the last byte has been accepted. It sits between the step/run FSM, the processor debug taps and the UART TX.

Parameters:
UART_BITS, 8, UART byte width
PC_BITS, 32, PC width; multiple of UART_BITS
CLK_COUNTER_BITS, 32, cycle counter width; multiple of UART_BITS
PROC_BITS, 32, register/memory word width; multiple of UART_BITS
RF_REGS_LEN, 1024, flattened register file width (32 regs x PROC_BITS), reg0 in bits [PROC_BITS-1:0]
DATA_ADDRS_BITS, 5, data memory address width; 2^DATA_ADDRS_BITS words dumped

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
i_send_start  in  1  one-cycle request to dump the snapshot
o_send_done  out  1  one-cycle pulse after the last byte's i_tx_done
i_pc  in  PC_BITS  current PC
i_clk_count  in  CLK_COUNTER_BITS  executed cycle count
i_rf_regs  in  RF_REGS_LEN  flattened register file
o_mem_addr  out  DATA_ADDRS_BITS  data memory debug read address
i_mem_data  in  PROC_BITS  read data, valid one cycle after o_mem_addr
o_tx_start  out  1  one-cycle pulse: UART TX loads o_tx_data
o_tx_data  out  UART_BITS  byte to transmit
i_tx_done  in  1  one-cycle pulse: UART TX finished a byte
o_busy  out  1  high from acceptance of i_send_start until o_send_done

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE; o_send_done=0, o_tx_start=0, o_tx_data=0, o_mem_addr=0, o_busy=0; all counters and the snapshot register cleared. Reset mid-dump aborts immediately; no o_send_done is emitted.
- All outputs are registered.
- States: IDLE, SNAP, TX_LOAD, TX_WAIT, MEM_REQ, MEM_LATCH, [CSUM], DONE.
- IDLE: i_send_start=1 -> SNAP; o_busy=1 from the next cycle. i_send_start is ignored in every other state.
- SNAP: latch i_pc, i_clk_count and i_rf_regs into a snapshot; byte index=0 -> TX_LOAD.
- Byte order: PC, then clk_count, then reg0..reg31, then mem[0]..mem[2^DATA_ADDRS_BITS-1]. Each field goes least-significant byte first.
- Defaults: 4+4+128+128 = 264 bytes.
- TX_LOAD: o_tx_data=current byte, o_tx_start=1 for exactly one cycle -> TX_WAIT.
- TX_WAIT: hold o_tx_data. On i_tx_done:
  - field bytes remaining -> TX_LOAD with the next byte;
  - register section finished or memory word finished -> MEM_REQ;
  - last memory byte finished -> DONE, or CSUM when the optional feature is enabled.
- i_tx_done is sampled only in TX_WAIT and never in the TX_LOAD cycle. Pulses arriving in other states are dropped.
- MEM_REQ: drive o_mem_addr=word index -> MEM_LATCH.
- MEM_LATCH: capture i_mem_data into the word buffer -> TX_LOAD. Memory is read live, not snapshotted; the processor is held disabled during the dump.
- Word index is DATA_ADDRS_BITS+1 wide, so the last word (31 at default) terminates without wrap to 0.
- DONE: o_send_done=1 for one cycle, o_busy=0 -> IDLE. A new i_send_start is accepted from the cycle after DONE.
- Latency: i_send_start at edge T -> first o_tx_start at edge T+2.
- Inter-byte gap: one cycle after i_tx_done for register-file bytes; three cycles at memory word boundaries.

Optional Feature:
SENDER_CHECKSUM_EN
- Defined: after the last memory byte, state CSUM transmits one extra byte: the XOR of all payload bytes (265 bytes total). o_send_done follows that byte's i_tx_done. The accumulator clears in SNAP.
- Undefined: no CSUM state; o_send_done follows the last payload byte; 264 bytes.

Test Plan:
- Reset: hold rst=0 for 5 cycles with i_send_start=1 -> all outputs 0, no o_tx_start.
- Basic dump: i_pc=0x00000010, i_clk_count=0x00000007, reg k = k, mem[k] = 0x100+k; TX model answers i_tx_done 5 cycles after each o_tx_start.
  - Expected: first bytes 0x10,0x00,0x00,0x00,0x07,0x00,...
  - Expected: reg1 bytes 0x01,0x00,0x00,0x00; mem[31] bytes 0x1F,0x01,0x00,0x00.
  - Expected: exactly 264 o_tx_start pulses, then one o_send_done.
- Snapshot stability: change i_pc to 0xFFFFFFFF one cycle after i_send_start -> PC bytes still 0x10,0x00,0x00,0x00.
- Busy ignore and spurious done: pulse i_send_start and i_tx_done while in TX_LOAD and MEM_REQ -> no restart and no extra byte; byte count stays 264.
- Abort: assert rst=0 after byte 100.
  - Expected: no o_send_done; o_busy=0.
  - Expected: a following i_send_start restarts from PC byte 0.
- SENDER_CHECKSUM_EN defined: all inputs 0 except i_pc=0x000000A5 -> 265 bytes, final byte 0xA5.

Source files
------------

// File: rtl/debug_data_sender.sv
// -----------------------------------------------------------------------------
// debug_data_sender
//
// Transmit side of the debug unit's send handshake. On a send-start pulse it
// snapshots PC, cycle count and the register file, then streams them followed
// by the live data memory contents to the UART transmitter one byte at a time,
// least-significant byte of each field first. A one-cycle send-done pulse
// follows the last byte's tx-done.
//
// Build option:
//   SENDER_CHECKSUM_EN - when defined, one extra byte holding the XOR of all
//                        payload bytes is sent after the last memory byte.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-low reset
//   i_send_start  one-cycle dump request (accepted in IDLE only)
//   o_send_done   one-cycle pulse after the final byte completes
//   i_pc          current PC
//   i_clk_count   executed cycle count
//   i_rf_regs     flattened register file, reg0 in the low word
//   o_mem_addr    data memory debug read address
//   i_mem_data    data memory read data
//   o_tx_start    one-cycle pulse: UART TX loads o_tx_data
//   o_tx_data     byte to transmit
//   i_tx_done     one-cycle pulse: UART TX finished a byte
//   o_busy        high while a dump is in progress
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for i_send_start
// SNAP      | latch PC / cycle count / register file, reset counters
// TX_LOAD   | present current byte and pulse o_tx_start
// TX_WAIT   | hold byte, wait for i_tx_done, pick next step
// MEM_REQ   | drive o_mem_addr with the current word index
// MEM_LATCH | capture i_mem_data into the word buffer
// CSUM      | (checksum build) present XOR of all payload bytes
// DONE      | pulse o_send_done, drop o_busy
// -----------------------------------------------------------------------------
module debug_data_sender #(
    parameter int UART_BITS        = 8,
    parameter int PC_BITS          = 32,
    parameter int CLK_COUNTER_BITS = 32,
    parameter int PROC_BITS        = 32,
    parameter int RF_REGS_LEN      = 1024,
    parameter int DATA_ADDRS_BITS  = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_send_start,
    output logic                        o_send_done,
    input  logic [PC_BITS-1:0]          i_pc,
    input  logic [CLK_COUNTER_BITS-1:0] i_clk_count,
    input  logic [RF_REGS_LEN-1:0]      i_rf_regs,
    output logic [DATA_ADDRS_BITS-1:0]  o_mem_addr,
    input  logic [PROC_BITS-1:0]        i_mem_data,
    output logic                        o_tx_start,
    output logic [UART_BITS-1:0]        o_tx_data,
    input  logic                        i_tx_done,
    output logic                        o_busy
);

    localparam int SNAP_BITS  = PC_BITS + CLK_COUNTER_BITS + RF_REGS_LEN;
    localparam int HDR_BYTES  = SNAP_BITS / UART_BITS;
    localparam int HDR_CNT_W  = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
    localparam int WORD_BYTES = PROC_BITS / UART_BITS;
    localparam int WB_CNT_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int WIDX_W     = DATA_ADDRS_BITS + 1;

    localparam logic [HDR_CNT_W-1:0] HDR_LAST  = HDR_CNT_W'(HDR_BYTES - 1);
    localparam logic [WB_CNT_W-1:0]  WB_LAST   = WB_CNT_W'(WORD_BYTES - 1);
    localparam logic [WIDX_W-1:0]    LAST_WORD = WIDX_W'((1 << DATA_ADDRS_BITS) - 1);

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        TX_LOAD,
        TX_WAIT,
        MEM_REQ,
        MEM_LATCH,
`ifdef SENDER_CHECKSUM_EN
        CSUM,
`endif
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SEC_HDR,
        SEC_MEM,
        SEC_CSUM
    } sec_t;

    state_t                 state_q;
    sec_t                   sec_q;
    logic [SNAP_BITS-1:0]   snap_q;
    logic [PROC_BITS-1:0]   word_q;
    logic [HDR_CNT_W-1:0]   hdr_cnt_q;
    logic [WB_CNT_W-1:0]    wb_cnt_q;
    logic [WIDX_W-1:0]      word_idx_q;
    logic                   send_done_q;
    logic                   tx_start_q;
    logic [UART_BITS-1:0]   tx_data_q;
    logic [DATA_ADDRS_BITS-1:0] mem_addr_q;
    logic                   busy_q;
`ifdef SENDER_CHECKSUM_EN
    logic [UART_BITS-1:0]   csum_q;
`endif

    // Snapshot and word buffer are shift registers; the byte on air is
    // always the low byte of whichever one is active.
    logic [UART_BITS-1:0] tx_byte_d;
    assign tx_byte_d = (sec_q == SEC_MEM) ? word_q[UART_BITS-1:0]
                                          : snap_q[UART_BITS-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            sec_q       <= SEC_HDR;
            snap_q      <= '0;
            word_q      <= '0;
            hdr_cnt_q   <= '0;
            wb_cnt_q    <= '0;
            word_idx_q  <= '0;
            send_done_q <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            mem_addr_q  <= '0;
            busy_q      <= 1'b0;
`ifdef SENDER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            tx_start_q  <= 1'b0;
            send_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_send_start) begin
                        busy_q  <= 1'b1;
                        state_q <= SNAP;
                    end
                end
                SNAP: begin
                    snap_q     <= {i_rf_regs, i_clk_count, i_pc};
                    hdr_cnt_q  <= HDR_LAST;
                    word_idx_q <= '0;
                    sec_q      <= SEC_HDR;
`ifdef SENDER_CHECKSUM_EN
                    csum_q     <= '0;
`endif
                    state_q    <= TX_LOAD;
                end
                TX_LOAD: begin
                    tx_data_q  <= tx_byte_d;
                    tx_start_q <= 1'b1;
`ifdef SENDER_CHECKSUM_EN
                    csum_q     <= csum_q ^ tx_byte_d;
`endif
                    state_q    <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (i_tx_done) begin
                        case (sec_q)
                            SEC_HDR: begin
                                if (hdr_cnt_q == '0) begin
                                    sec_q   <= SEC_MEM;
                                    state_q <= MEM_REQ;
                                end else begin
                                    snap_q    <= snap_q >> UART_BITS;
                                    hdr_cnt_q <= hdr_cnt_q - HDR_CNT_W'(1);
                                    state_q   <= TX_LOAD;
                                end
                            end
                            SEC_MEM: begin
                                if (wb_cnt_q != '0) begin
                                    word_q   <= word_q >> UART_BITS;
                                    wb_cnt_q <= wb_cnt_q - WB_CNT_W'(1);
                                    state_q  <= TX_LOAD;
                                end else if (word_idx_q == LAST_WORD) begin
`ifdef SENDER_CHECKSUM_EN
                                    state_q <= CSUM;
`else
                                    state_q <= DONE;
`endif
                                end else begin
                                    word_idx_q <= word_idx_q + WIDX_W'(1);
                                    state_q    <= MEM_REQ;
                                end
                            end
                            default: state_q <= DONE;
                        endcase
                    end
                end
                MEM_REQ: begin
                    mem_addr_q <= word_idx_q[DATA_ADDRS_BITS-1:0];
                    state_q    <= MEM_LATCH;
                end
                MEM_LATCH: begin
                    word_q   <= i_mem_data;
                    wb_cnt_q <= WB_LAST;
                    state_q  <= TX_LOAD;
                end
`ifdef SENDER_CHECKSUM_EN
                CSUM: begin
                    tx_data_q  <= csum_q;
                    tx_start_q <= 1'b1;
                    sec_q      <= SEC_CSUM;
                    state_q    <= TX_WAIT;
                end
`endif
                DONE: begin
                    send_done_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_send_done = send_done_q;
    assign o_tx_start  = tx_start_q;
    assign o_tx_data   = tx_data_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_debug_data_sender.sv
module tb_debug_data_sender;

`ifdef SENDER_CHECKSUM_EN
    localparam int N_BYTES = 265;
`else
    localparam int N_BYTES = 264;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_send_start = 1'b0;
    logic          o_send_done;
    logic [31:0]   i_pc = 32'h0;
    logic [31:0]   i_clk_count = 32'h0;
    logic [1023:0] i_rf_regs = '0;
    logic [4:0]    o_mem_addr;
    logic [31:0]   i_mem_data;
    logic          o_tx_start;
    logic [7:0]    o_tx_data;
    logic          i_tx_done;
    logic          o_busy;

    logic          tx_done_model = 1'b0;
    logic          tx_done_spur = 1'b0;
    logic          mem_zero = 1'b0;
    int            tx_cd = 0;

    int            tests = 0;
    int            fails = 0;
    int            tx_count = 0;
    int            done_cnt = 0;
    int            done_base = 0;
    logic [7:0]    last_byte = 8'h0;
    logic [7:0]    got [0:299];
    logic [7:0]    exp_q [$];

    always #5 clk = ~clk;

    assign i_tx_done  = tx_done_model | tx_done_spur;
    assign i_mem_data = mem_zero ? 32'h0 : (32'h100 + {27'h0, o_mem_addr});

    debug_data_sender dut (
        .clk          (clk),
        .rst          (rst),
        .i_send_start (i_send_start),
        .o_send_done  (o_send_done),
        .i_pc         (i_pc),
        .i_clk_count  (i_clk_count),
        .i_rf_regs    (i_rf_regs),
        .o_mem_addr   (o_mem_addr),
        .i_mem_data   (i_mem_data),
        .o_tx_start   (o_tx_start),
        .o_tx_data    (o_tx_data),
        .i_tx_done    (i_tx_done),
        .o_busy       (o_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // UART TX model: done pulse five cycles after each start
    always @(negedge clk) begin
        tx_done_model = 1'b0;
        if (tx_cd != 0) begin
            tx_cd--;
            if (tx_cd == 0) tx_done_model = 1'b1;
        end
        if (o_tx_start) tx_cd = 5;
    end

    // Monitor: pop expected byte on every tx start
    always @(negedge clk) begin
        if (o_tx_start) begin
            if (tx_count < 300) got[tx_count] = o_tx_data;
            last_byte = o_tx_data;
            tx_count++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_byte: got 0x%0h with nothing expected", o_tx_data);
            end else begin
                check("tx_byte", 64'(o_tx_data), 64'(exp_q.pop_front()));
            end
        end
        if (o_send_done) done_cnt++;
    end

    task automatic build_expect(input logic [31:0] pc, input logic [31:0] cc,
                                input bit rf_zero, input bit mz);
        logic [7:0]  cs;
        logic [31:0] w;
        cs = 8'h0;
        for (int i = 0; i < 4; i++) begin exp_q.push_back(pc[8*i +: 8]); cs ^= pc[8*i +: 8]; end
        for (int i = 0; i < 4; i++) begin exp_q.push_back(cc[8*i +: 8]); cs ^= cc[8*i +: 8]; end
        for (int k = 0; k < 32; k++) begin
            w = rf_zero ? 32'h0 : k;
            for (int i = 0; i < 4; i++) begin exp_q.push_back(w[8*i +: 8]); cs ^= w[8*i +: 8]; end
        end
        for (int k = 0; k < 32; k++) begin
            w = mz ? 32'h0 : (32'h100 + k);
            for (int i = 0; i < 4; i++) begin exp_q.push_back(w[8*i +: 8]); cs ^= w[8*i +: 8]; end
        end
`ifdef SENDER_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    task automatic prep();
        tx_count  = 0;
        done_base = done_cnt;
    endtask

    task automatic start_dump(input bit stab, input bit spur);
        @(posedge clk); #1 i_send_start = 1'b1;
        @(posedge clk); #1 i_send_start = 1'b0;
        @(negedge clk);
        check("busy_after_accept", 64'(o_busy), 64'd1);
        check("no_start_at_T1", 64'(o_tx_start), 64'd0);
        @(posedge clk); #1;
        if (stab) i_pc = 32'hFFFF_FFFF;
        if (spur) begin i_send_start = 1'b1; tx_done_spur = 1'b1; end
        @(negedge clk);
        check("no_start_before_T2", 64'(o_tx_start), 64'd0);
        @(posedge clk); #1 i_send_start = 1'b0; tx_done_spur = 1'b0;
        @(negedge clk);
        check("first_start_latency", 64'(o_tx_start), 64'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt == done_base && n < 6000) begin @(negedge clk); #1; n++; end
        if (n >= 6000) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no send_done after %0d cycles, required one", n);
        end
        @(negedge clk); #1;
        check("done_single_pulse", 64'(o_send_done), 64'd0);
        check("done_count", 64'(done_cnt - done_base), 64'd1);
        check("byte_count", 64'(tx_count), 64'(N_BYTES));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("busy_cleared", 64'(o_busy), 64'd0);
    endtask

    initial begin
        logic [7:0] hc [0:13];
        int n;
        hc = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00,
               8'h01, 8'h00, 8'h00, 8'h00, 8'h1F, 8'h01, 8'h00, 8'h00};

        for (int k = 0; k < 32; k++) i_rf_regs[32*k +: 32] = k;
        i_pc        = 32'h0000_0010;
        i_clk_count = 32'h0000_0007;

        // reset held with a start request
        rst = 1'b0;
        i_send_start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); @(negedge clk);
            check("reset_outputs", 64'({o_send_done, o_tx_start, o_tx_data, o_mem_addr, o_busy}), 64'd0);
        end
        check("reset_no_tx", 64'(tx_count), 64'd0);
        @(posedge clk); #1 rst = 1'b1; i_send_start = 1'b0;
        repeat (2) @(posedge clk);

        // basic dump with PC changed after the snapshot
        prep();
        build_expect(32'h10, 32'h7, 1'b0, 1'b0);
        start_dump(1'b1, 1'b0);
        wait_done();
        for (int i = 0; i < 6; i++) check("hdr_byte", 64'(got[i]), 64'(hc[i]));
        for (int i = 0; i < 4; i++) check("reg1_byte", 64'(got[12+i]), 64'(hc[6+i]));
        for (int i = 0; i < 4; i++) check("mem31_byte", 64'(got[260+i]), 64'(hc[10+i]));
        i_pc = 32'h0000_0010;

        // spurious start / done in TX_LOAD and MEM_REQ
        prep();
        build_expect(32'h10, 32'h7, 1'b0, 1'b0);
        start_dump(1'b0, 1'b1);
        n = 0;
        while (!(tx_count == 136 && tx_done_model) && n < 3000) begin @(negedge clk); #1; n++; end
        check("reach_mem_req", 64'(n < 3000), 64'd1);
        @(posedge clk); #1 i_send_start = 1'b1; tx_done_spur = 1'b1;
        @(posedge clk); #1 i_send_start = 1'b0; tx_done_spur = 1'b0;
        wait_done();

        // abort after byte 100
        prep();
        build_expect(32'h10, 32'h7, 1'b0, 1'b0);
        start_dump(1'b0, 1'b0);
        n = 0;
        while (tx_count < 100 && n < 3000) begin @(negedge clk); #1; n++; end
        check("reach_byte_100", 64'(tx_count), 64'd100);
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("abort_busy", 64'(o_busy), 64'd0);
        check("abort_tx_start", 64'(o_tx_start), 64'd0);
        check("abort_no_done", 64'(done_cnt - done_base), 64'd0);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        prep();
        build_expect(32'h10, 32'h7, 1'b0, 1'b0);
        start_dump(1'b0, 1'b0);
        wait_done();
        check("restart_pc_byte0", 64'(got[0]), 64'h10);

`ifdef SENDER_CHECKSUM_EN
        // checksum over an all-zero payload except PC
        i_pc        = 32'h0000_00A5;
        i_clk_count = 32'h0;
        i_rf_regs   = '0;
        mem_zero    = 1'b1;
        prep();
        build_expect(32'hA5, 32'h0, 1'b1, 1'b1);
        start_dump(1'b0, 1'b0);
        wait_done();
        check("csum_final_byte", 64'(last_byte), 64'hA5);
`endif

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
